// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constant builders for the digit-serial adder/subtractor
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int ndig);
        return (ndig <= 2) ? 1 : $clog2(ndig);
    endfunction

    // Saturation bounds are built 64 bits wide and sliced to WIDTH by the user.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-bit ripple-carry slice
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] sum_d,
    output logic             cout_d,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum_d[i] = a_d[i] ^ b_d[i] ^ c[i];
        assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end

    assign cout_d   = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial add/sub with handshakes; ADDSUB_SAT_EN enables signed saturation
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_sr, b_sr, s_r;
    logic [CW-1:0]     cnt;
    logic              carry, cout_r, ovf_r, zero_r;
    logic [DIGIT-1:0]  sum_d;
    logic              cout_d, c_msb_in;
    logic              last, ovf_d;
    logic [WIDTH-1:0]  s_shift, s_fin;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d      (a_sr[DIGIT-1:0]),
        .b_d      (b_sr[DIGIT-1:0]),
        .cin      (carry),
        .sum_d    (sum_d),
        .cout_d   (cout_d),
        .c_msb_in (c_msb_in)
    );

    assign last    = (cnt == CW'(NDIG - 1));
    assign ovf_d   = c_msb_in ^ cout_d;
    assign s_shift = (s_r >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));

`ifdef ADDSUB_SAT_EN
    localparam logic [63:0]      SAT_MAX64 = sat_max(WIDTH);
    localparam logic [63:0]      SAT_MIN64 = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN64[WIDTH-1:0];

    // On overflow both operands share a sign; the top digit of a_sr still holds it.
    always_comb begin
        s_fin = s_shift;
        if (last && ovf_d) begin
            s_fin = a_sr[DIGIT-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign s_fin = s_shift;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_n = RUN;
            end
            RUN: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_r    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    s_r   <= s_fin;
                    carry <= cout_d;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cout_r <= cout_d;
                        ovf_r  <= ovf_d;
                        zero_r <= (s_fin == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - randomized self-checking bench for addsub_serial (8x1 and 16x4 instances)
module tb_addsub_serial;

    logic        clk, rst;
    logic        iv8, ir8, sub8, ov8, or8, c8, o8, z8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, ir16, sub16, ov16, or16, c16, o16, z16;
    logic [15:0] a16, b16, s16;
    int          checks, failures;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .s(s8), .cout(c8), .ovf(o8), .zero(z8)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .s(s16), .cout(c16), .ovf(o16), .zero(z16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer arithmetic on signed/unsigned interpretations of the operands.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, output logic [15:0] s, output logic c,
                                  output logic o, output logic z);
        longint mask, ua, ub, full, sa, sb, r, maxv, minv, res;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = sub ? (ua - ub + (mask + 1)) : (ua + ub);
        c    = ((full >> w) & 1) != 0;
        sa   = (ua > (mask >> 1)) ? ua - (mask + 1) : ua;
        sb   = (ub > (mask >> 1)) ? ub - (mask + 1) : ub;
        r    = sub ? (sa - sb) : (sa + sb);
        maxv = mask >> 1;
        minv = -(maxv + 1);
        o    = (r > maxv) || (r < minv);
        res  = full & mask;
`ifdef ADDSUB_SAT_EN
        if (o) res = (r > 0) ? maxv : (minv & mask);
`endif
        s = res[15:0];
        z = (res == 0);
    endfunction

    task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output logic [15:0] s, output logic c, output logic o, output logic z,
                          output int lat);
        @(negedge clk);
        if (w16) begin a16 = a; b16 = b; sub16 = sub; iv16 = 1'b1; end
        else     begin a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; iv8 = 1'b1; end
        @(posedge clk); #1;
        iv8 = 1'b0; iv16 = 1'b0; lat = 0;
        while (!(w16 ? ov16 : ov8) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (w16) begin s = s16; c = c16; o = o16; z = z16; end
        else     begin s = {8'h00, s8}; c = c8; o = o8; z = z8; end
        @(negedge clk);
        if (w16) or16 = 1'b1; else or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0; or16 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ir8 !== 1'b0 || ir16 !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_low got=%b/%b want=0/0", ir8, ir16);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ir8, ov8, s8, c8, o8, z8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_state8 got ir=%b ov=%b s=%h c=%b o=%b z=%b want ir=1 ov=0 s=00 flags=0",
                     ir8, ov8, s8, c8, o8, z8);
        end
        checks++;
        if ({ir16, ov16, s16, c16, o16, z16} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL reset_state16 got ir=%b ov=%b s=%h c=%b o=%b z=%b want ir=1 ov=0 s=0000 flags=0",
                     ir16, ov16, s16, c16, o16, z16);
        end
    endtask

    task automatic test_directed;
        logic [15:0] ta[7], tb[7], s, es;
        logic        tsub[7], c, o, z, ec, eo, ez;
        int          lat;
        ta   = '{16'h05, 16'h01, 16'h03, 16'h7F, 16'h80, 16'hFF, 16'h00};
        tb   = '{16'h03, 16'h03, 16'h03, 16'h01, 16'h01, 16'h01, 16'h00};
        tsub = '{1'b1,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, ta[i], tb[i], tsub[i], s, c, o, z, lat);
            model(8, ta[i], tb[i], tsub[i], es, ec, eo, ez);
            checks++;
            if ({s, c, o, z} !== {es, ec, eo, ez} || lat != 8) begin
                failures++;
                $display("FAIL directed%0d a=%h b=%h sub=%b got s=%h c=%b o=%b z=%b lat=%0d want s=%h c=%b o=%b z=%b lat=8",
                         i, ta[i], tb[i], tsub[i], s, c, o, z, lat, es, ec, eo, ez);
            end
        end
    endtask

    task automatic test_random(input bit w16, input int n);
        logic [15:0] a, b, s, es;
        logic        sb, c, o, z, ec, eo, ez;
        int          lat, w, nd;
        w  = w16 ? 16 : 8;
        nd = w16 ? 4 : 8;
        for (int i = 0; i < n; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            sb = 1'($urandom);
            if (!w16) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
            run_op(w16, a, b, sb, s, c, o, z, lat);
            model(w, a, b, sb, es, ec, eo, ez);
            checks++;
            if ({s, c, o, z} !== {es, ec, eo, ez} || lat != nd) begin
                failures++;
                $display("FAIL random_w%0d a=%h b=%h sub=%b got s=%h c=%b o=%b z=%b lat=%0d want s=%h c=%b o=%b z=%b lat=%0d",
                         w, a, b, sb, s, c, o, z, lat, es, ec, eo, ez, nd);
            end
        end
    endtask

    task automatic test_wide;
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, s, c, o, z, lat);
        checks++;
        if (s !== 16'h0000 || c !== 1'b1 || o !== 1'b0 || z !== 1'b1 || lat != 4) begin
            failures++;
            $display("FAIL wide_wrap got s=%h c=%b o=%b z=%b lat=%0d want s=0000 c=1 o=0 z=1 lat=4",
                     s, c, o, z, lat);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  hs;
        logic        hc, ho, hz, bad;
        logic [15:0] es, s;
        logic        ec, eo, ez, c, o, z;
        int          lat;
        @(negedge clk); a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1; iv8 = 1'b0; lat = 0;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
        hs = s8; hc = c8; ho = o8; hz = z8;
        checks++;
        if (hs !== 8'h46 || {hc, ho, hz} !== 3'b000 || lat != 8) begin
            failures++;
            $display("FAIL bp_result got s=%h c=%b o=%b z=%b lat=%0d want s=46 flags=0 lat=8", hs, hc, ho, hz, lat);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk); #1;
            bad = (s8 !== hs) || ({c8, o8, z8} !== {hc, ho, hz}) || (ir8 !== 1'b0) || (ov8 !== 1'b1);
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got s=%h c=%b o=%b z=%b ir=%b ov=%b want s=%h c=%b o=%b z=%b ir=0 ov=1",
                         i, s8, c8, o8, z8, ir8, ov8, hs, hc, ho, hz);
            end
        end
        @(negedge clk); iv8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== hs) begin
            failures++;
            $display("FAIL bp_release got ir=%b ov=%b s=%h want ir=1 ov=0 s=%h", ir8, ov8, s8, hs);
        end
        or8 = 1'b1;
        run_op(1'b0, 16'h00C8, 16'h0037, 1'b1, s, c, o, z, lat);
        model(8, 16'h00C8, 16'h0037, 1'b1, es, ec, eo, ez);
        checks++;
        if ({s, c, o, z} !== {es, ec, eo, ez} || lat != 8) begin
            failures++;
            $display("FAIL early_ready got s=%h c=%b o=%b z=%b lat=%0d want s=%h c=%b o=%b z=%b lat=8",
                     s, c, o, z, lat, es, ec, eo, ez);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        @(negedge clk); a8 = 8'hA5; b8 = 8'h3C; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1; iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1; #1;
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b0 || s8 !== 8'h00 || {c8, o8, z8} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid got ov=%b ir=%b s=%h c=%b o=%b z=%b want ov=0 ir=0 s=00 flags=0",
                     ov8, ir8, s8, c8, o8, z8);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (ir8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_idle got ir=%b want ir=1", ir8);
        end
        run_op(1'b0, 16'h000F, 16'h0001, 1'b0, s, c, o, z, lat);
        checks++;
        if (s !== 16'h0010 || {c, o, z} !== 3'b000 || lat != 8) begin
            failures++;
            $display("FAIL reset_mid_after got s=%h c=%b o=%b z=%b lat=%0d want s=0010 flags=0 lat=8",
                     s, c, o, z, lat);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
        test_reset;
        test_directed;
        test_random(1'b0, 40);
        test_wide;
        test_random(1'b1, 30);
        test_backpressure;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
